// File: rtl/load_store_unit_if.sv
// Request/response channel between the core-side requester and the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [1:0]            req_size;
  logic                  req_extend;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_extend,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_extend,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide synchronous RAM without byte enables;
// sub-word stores are performed as read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                state;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [1:0]            lat_size;
  logic                  lat_extend;
  logic [31:0]           buffer;

  function automatic logic illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_WORD: bad = (off != 2'd0);
      SZ_HALF: bad = off[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] shape(input logic [31:0] rdata, input logic [1:0] size,
                                        input logic [1:0] off, input logic extend);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{extend & shifted[7]}}, shifted[7:0]};
      SZ_HALF: res = {{16{extend & shifted[15]}}, shifted[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Lanes outside the mask keep the RAM's current contents.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {off, 3'b000};
        data = {16'h0000, wdata[15:0]} << {off, 3'b000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  assign bus.req_ready = (state == IDLE);

  // Memory strobes decoded from state; they fall with the asynchronous reset of state.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    case (state)
      RD: begin
        mem_en   = 1'b1;
        mem_addr = lat_addr[ADDR_WIDTH-1:2];
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_addr[ADDR_WIDTH-1:2];
        mem_wdata = buffer;
      end
      default: begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Sequencer with registered response outputs and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= 32'h0000_0000;
      lat_size       <= 2'd0;
      lat_extend     <= 1'b0;
      buffer         <= 32'h0000_0000;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0000_0000;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid <= 1'b0;
          if (bus.req_valid) begin
            lat_write  <= bus.req_write;
            lat_addr   <= bus.req_addr;
            lat_wdata  <= bus.req_wdata;
            lat_size   <= bus.req_size;
            lat_extend <= bus.req_extend;
            buffer     <= bus.req_wdata;
            if (illegal(bus.req_size, bus.req_addr[1:0])) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0000_0000;
            end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          if (lat_write) begin
            buffer <= merge(mem_rdata, lat_wdata, lat_size, lat_addr[1:0]);
            state  <= WR;
          end else begin
            bus.resp_rdata <= shape(mem_rdata, lat_size, lat_addr[1:0], lat_extend);
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WR: begin
          bus.resp_rdata <= 32'h0000_0000;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0000_0000;
          state          <= IDLE;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous RAM.
module tb_load_store_unit;
  logic        clk;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  int          nops;
  int          nwr;
  logic [7:0]  seq;
  logic [29:0] last_waddr;

  int total;
  int bad;

  load_store_unit_if #(.ADDR_WIDTH(32)) lsu ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (lsu.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus backdoor preload and an activity log.
  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_data;
    if (mem_en) begin
      nops <= nops + 1;
      seq  <= {seq[6:0], mem_we};
      if (mem_we) begin
        ram[mem_addr[5:0]] <= mem_wdata;
        nwr        <= nwr + 1;
        last_waddr <= mem_addr;
      end else begin
        mem_rdata <= ram[mem_addr[5:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic ex,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic pulse_ok);
    @(negedge clk);
    lsu.req_valid  = 1'b1;
    lsu.req_write  = w;
    lsu.req_addr   = a;
    lsu.req_wdata  = wd;
    lsu.req_size   = sz;
    lsu.req_extend = ex;
    @(posedge clk);
    #1;
    lsu.req_valid = 1'b0;
    lat = 1;
    while (!lsu.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!lsu.resp_valid) lat = 99;
    rd = lsu.resp_rdata;
    er = lsu.resp_err;
    @(posedge clk);
    #1;
    pulse_ok = !lsu.resp_valid;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        pk;
    int          lat;
    int          ops0;
    int          wr0;
    int          vld_seen;

    total = 0; bad = 0;
    nops = 0; nwr = 0; seq = 8'h00; last_waddr = 30'h0; mem_rdata = 32'h0;
    pre_en = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
    lsu.req_valid = 1'b0; lsu.req_write = 1'b0; lsu.req_addr = 32'h0;
    lsu.req_wdata = 32'h0; lsu.req_size = 2'd0; lsu.req_extend = 1'b0;
    rst = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, lsu.req_ready}, 32'd1);
    check("rst_valid", {31'd0, lsu.resp_valid}, 32'd0);
    check("rst_err",   {31'd0, lsu.resp_err}, 32'd0);
    check("rst_rdata", lsu.resp_rdata, 32'h0);
    check("rst_memen", {31'd0, mem_en}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    pre_en = 1'b1; pre_idx = 6'd4; pre_data = 32'h8899AABB;
    @(negedge clk);
    pre_en = 1'b0;

    // Loads from word 0x10 = 0x8899AABB
    ops0 = nops;
    access(1'b0, 32'h12, 32'h0, 2'd2, 1'b1, rd, er, lat, pk);
    check("lb_data", rd, 32'hFFFFFF99);
    check("lb_err", {31'd0, er}, 32'd0);
    check("lb_lat", lat, 32'd3);
    check("lb_pulse", {31'd0, pk}, 32'd1);
    check("lb_strobes", nops - ops0, 32'd1);

    access(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, rd, er, lat, pk);
    check("lbu_data", rd, 32'h00000099);
    access(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd, er, lat, pk);
    check("lh_data", rd, 32'hFFFF8899);
    access(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, rd, er, lat, pk);
    check("lhu_data", rd, 32'h0000AABB);
    access(1'b0, 32'h10, 32'h0, 2'd0, 1'b1, rd, er, lat, pk);
    check("lw_data", rd, 32'h8899AABB);
    check("lw_lat", lat, 32'd3);

    // Byte store: read-modify-write
    ops0 = nops; wr0 = nwr;
    access(1'b1, 32'h11, 32'h12345655, 2'd2, 1'b0, rd, er, lat, pk);
    check("sb_lat", lat, 32'd4);
    check("sb_rdata", rd, 32'h0);
    check("sb_ops", nops - ops0, 32'd2);
    check("sb_order", {30'd0, seq[1:0]}, 32'd1);
    check("sb_ram", ram[4], 32'h889955BB);

    // Word store: single write cycle
    ops0 = nops; wr0 = nwr;
    access(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, rd, er, lat, pk);
    check("sw_lat", lat, 32'd2);
    check("sw_ops", nops - ops0, 32'd1);
    check("sw_wr", nwr - wr0, 32'd1);
    check("sw_waddr", {2'b00, last_waddr}, 32'h4);
    check("sw_ram", ram[4], 32'hDEADBEEF);

    // Illegal accesses
    ops0 = nops;
    access(1'b0, 32'h13, 32'h0, 2'd1, 1'b1, rd, er, lat, pk);
    check("err_lh_err", {31'd0, er}, 32'd1);
    check("err_lh_lat", lat, 32'd1);
    check("err_lh_rdata", rd, 32'h0);
    access(1'b1, 32'h12, 32'hCAFEF00D, 2'd0, 1'b0, rd, er, lat, pk);
    check("err_sw_err", {31'd0, er}, 32'd1);
    check("err_sw_lat", lat, 32'd1);
    access(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, rd, er, lat, pk);
    check("err_sz3_err", {31'd0, er}, 32'd1);
    check("err_sz3_lat", lat, 32'd1);
    check("err_pulse", {31'd0, pk}, 32'd1);
    check("err_no_mem", nops - ops0, 32'd0);
    check("err_ram", ram[4], 32'hDEADBEEF);

    // Reset during CAP of a halfword store
    wr0 = nwr;
    vld_seen = 0;
    @(negedge clk);
    lsu.req_valid = 1'b1; lsu.req_write = 1'b1; lsu.req_addr = 32'h10;
    lsu.req_wdata = 32'h00001234; lsu.req_size = 2'd1; lsu.req_extend = 1'b0;
    @(posedge clk);
    #1;
    lsu.req_valid = 1'b0;
    check("sh_rd_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("sh_rst_en", {31'd0, mem_en}, 32'd0);
    check("sh_rst_we", {31'd0, mem_we}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (lsu.resp_valid) vld_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (lsu.resp_valid) vld_seen++;
    end
    check("sh_no_resp", vld_seen, 32'd0);
    check("sh_no_write", nwr - wr0, 32'd0);
    check("sh_ready", {31'd0, lsu.req_ready}, 32'd1);
    check("sh_ram", ram[4], 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, rd, er, lat, pk);
    check("post_rst_lw", rd, 32'hDEADBEEF);

    // Reset during RD drops the read strobe asynchronously
    @(negedge clk);
    lsu.req_valid = 1'b1; lsu.req_write = 1'b0; lsu.req_addr = 32'h10;
    lsu.req_size = 2'd0;
    @(posedge clk);
    #1;
    lsu.req_valid = 1'b0;
    check("rd_en_pre", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rd_en_rst", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
